sensor_poll_scheduler: RTL and testbench

//  Timebase + sequencer for the avionics sensor bus. Divides CLK_1MHZ_IN to a 100 kHz tick
//  (same ratio as the existing 1 MHz->100 kHz divider), counts ticks into fixed frames and,

---
 rtl/sensor_sched_pkg.sv | 18 +
 rtl/tick_frame_gen.sv | 45 ++++
 rtl/sensor_poll_scheduler.sv | 156 +++++++++++++++
 tb/tb_sensor_poll_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_sched_pkg.sv
// rtl/sensor_sched_pkg.sv - shared state type and default timebase constants for the sensor poll scheduler
package sensor_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SCAN     = 2'd1,
        ST_REQ_WAIT = 2'd2,
        ST_GAP      = 2'd3
    } sched_state_t;

    // Defaults for a 1 MHz system clock: 100 kHz tick, 10 ms frame, 0.5 ms slot timeout.
    localparam int DEF_NUM_SLOTS     = 4;
    localparam int DEF_TICK_DIV      = 10;
    localparam int DEF_FRAME_TICKS   = 1000;
    localparam int DEF_TIMEOUT_TICKS = 50;
    localparam int DEF_FCNT_W        = 16;

endpackage

// File: rtl/tick_frame_gen.sv
// rtl/tick_frame_gen.sv - prescaler and frame counter producing a tick strobe and a frame boundary strobe
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   tick         1-cycle strobe every TICK_DIV clocks (first on the TICK_DIV-th clock after reset)
//   frame_start  1-cycle strobe on the tick that completes FRAME_TICKS ticks
module tick_frame_gen
    import sensor_sched_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick,
    output logic frame_start
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_TICKS - 1);

    logic [PW-1:0] pre_cnt;
    logic [FW-1:0] tick_cnt;

    // Strobes are pure decodes of the counter registers, so they are glitch-free
    // and line up with the cycle the count reaches its terminal value.
    assign tick        = (pre_cnt == PRE_LAST);
    assign frame_start = tick && (tick_cnt == FRAME_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) begin
                tick_cnt <= frame_start ? '0 : tick_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// rtl/sensor_poll_scheduler.sv - frame timebase and one-at-a-time request sequencer for sensor reader slots
//
// Ports:
//   clk_1mhz_in    system clock
//   reset_n        asynchronous active-low reset
//   enable         run frames; dropping it lets the current request finish, then stops
//   slot_mask      per-slot enable, captured only on the frame_start cycle
//   clr_flags      pulse clearing timeout_flags and overrun (a coincident new event wins)
//   done           per-slot completion from the readers; only the requested slot counts
//   req            one-hot or zero request, held until done or timeout
//   tick_100khz    1-cycle tick strobe
//   frame_start    1-cycle frame boundary strobe
//   busy           a frame's slot sequence is in progress
//   timeout_flags  sticky per-slot timeout record
//   overrun        sticky: a frame boundary arrived while busy
//   frame_count    frames started, wrapping
module sensor_poll_scheduler
    import sensor_sched_pkg::*;
#(
    parameter int NUM_SLOTS     = DEF_NUM_SLOTS,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int FRAME_TICKS   = DEF_FRAME_TICKS,
    parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
    parameter int FCNT_W        = DEF_FCNT_W
) (
    input  logic                 clk_1mhz_in,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [NUM_SLOTS-1:0] slot_mask,
    input  logic                 clr_flags,
    input  logic [NUM_SLOTS-1:0] done,
    output logic [NUM_SLOTS-1:0] req,
    output logic                 tick_100khz,
    output logic                 frame_start,
    output logic                 busy,
    output logic [NUM_SLOTS-1:0] timeout_flags,
    output logic                 overrun,
    output logic [FCNT_W-1:0]    frame_count
);

    localparam int PTR_W = $clog2(NUM_SLOTS + 1);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    if (TIMEOUT_TICKS >= FRAME_TICKS) begin : g_timeout_check
        $error("sensor_poll_scheduler: TIMEOUT_TICKS must be less than FRAME_TICKS");
    end

    tick_frame_gen #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timebase (
        .clk         (clk_1mhz_in),
        .rst_n       (reset_n),
        .tick        (tick_100khz),
        .frame_start (frame_start)
    );

    sched_state_t         state;
    logic [NUM_SLOTS-1:0] mask_q;
    logic [PTR_W-1:0]     ptr;
    logic [IDX_W-1:0]     cur;
    logic [TO_W-1:0]      to_cnt;

    logic                 found;
    logic [IDX_W-1:0]     found_idx;
    logic                 done_hit;
    logic                 timeout_hit;

    // Lowest latched slot at or above the pointer; scanning downwards lets the
    // last assignment be the lowest match.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask_q[i] && (PTR_W'(i) >= ptr)) begin
                found     = 1'b1;
                found_idx = IDX_W'(i);
            end
        end
    end

    // Masking with req ignores done from any slot not currently requested.
    assign done_hit    = |(done & req);
    assign timeout_hit = tick_100khz && (to_cnt == TO_LAST);

    always_ff @(posedge clk_1mhz_in or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            mask_q        <= '0;
            ptr           <= '0;
            cur           <= '0;
            to_cnt        <= '0;
            req           <= '0;
            busy          <= 1'b0;
            timeout_flags <= '0;
            overrun       <= 1'b0;
            frame_count   <= '0;
        end else begin
            if (frame_start) begin
                frame_count <= frame_count + 1'b1;
            end

            // Clear is written first so that any set below in the same cycle takes effect.
            if (clr_flags) begin
                timeout_flags <= '0;
                overrun       <= 1'b0;
            end
            if (frame_start && busy) begin
                overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start && enable) begin
                        mask_q <= slot_mask;
                        ptr    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (found && enable) begin
                        req            <= '0;
                        req[found_idx] <= 1'b1;
                        cur            <= found_idx;
                        to_cnt         <= '0;
                        state          <= ST_REQ_WAIT;
                    end else begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_REQ_WAIT: begin
                    if (done_hit) begin
                        req   <= '0;
                        state <= ST_GAP;
                    end else if (timeout_hit) begin
                        req                <= '0;
                        timeout_flags[cur] <= 1'b1;
                        state              <= ST_GAP;
                    end else if (tick_100khz) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    ptr   <= PTR_W'(cur) + PTR_W'(1);
                    state <= ST_SCAN;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// tb/tb_sensor_poll_scheduler.sv - scoreboard bench for sensor_poll_scheduler
module tb_sensor_poll_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        enable, clr_flags;
    logic [3:0]  slot_mask, done, req, timeout_flags;
    logic        tick, frame_start, busy, overrun;
    logic [15:0] frame_count;

    logic        enable2, clr2;
    logic [3:0]  mask2, done2, req2, flags2;
    logic        tick2, fs2, busy2, overrun2;
    logic [15:0] fcount2;

    sensor_poll_scheduler dut (
        .clk_1mhz_in   (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .slot_mask     (slot_mask),
        .clr_flags     (clr_flags),
        .done          (done),
        .req           (req),
        .tick_100khz   (tick),
        .frame_start   (frame_start),
        .busy          (busy),
        .timeout_flags (timeout_flags),
        .overrun       (overrun),
        .frame_count   (frame_count)
    );

    // Short-frame instance so a full-timeout sequence overruns the next frame.
    sensor_poll_scheduler #(.FRAME_TICKS(100)) dut_ov (
        .clk_1mhz_in   (clk),
        .reset_n       (reset_n),
        .enable        (enable2),
        .slot_mask     (mask2),
        .clr_flags     (clr2),
        .done          (done2),
        .req           (req2),
        .tick_100khz   (tick2),
        .frame_start   (fs2),
        .busy          (busy2),
        .timeout_flags (flags2),
        .overrun       (overrun2),
        .frame_count   (fcount2)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int fs_cyc = 0;

    logic [3:0] exp_q[$];
    logic [3:0] prev_req = '0;
    logic [3:0] resp_mask;
    int         resp_delay;
    int         resp_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_frame(input int bound, input string name);
        int n = 0;
        while (!frame_start && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(frame_start), 32'd1);
        fs_cyc = cyc;
    endtask

    task automatic wait_req(input logic [3:0] v, input int bound, input string name);
        int n = 0;
        while (req !== v && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(req), 32'(v));
    endtask

    task automatic wait_idle(input int bound, input string name);
        int n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Monitor: every new request is popped against the scoreboard.
    logic [3:0] exp_slot;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_req = '0;
        end else begin
            if (req != '0 && prev_req == '0) begin
                check("req_onehot", 32'($countones(req)), 32'd1);
                if (exp_q.size() == 0) begin
                    check("req_unexpected", 32'(req), 32'd0);
                end else begin
                    exp_slot = exp_q.pop_front();
                    check("req_order", 32'(req), 32'(exp_slot));
                end
            end else if (req != '0 && req != prev_req) begin
                check("req_no_gap", 32'(req), 32'(prev_req));
            end
            prev_req = req;
        end
    end

    // Reader model: answers a request resp_delay clocks after it appears.
    initial begin
        done = '0;
        resp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            done = '0;
            if (req == '0) begin
                resp_cnt = 0;
            end else if ((req & resp_mask) != '0) begin
                resp_cnt++;
                if (resp_cnt == resp_delay) done = req;
            end
        end
    end

    int tick_err, fs_cnt, fs_at, req_err, t_on, dur, fa, n;

    initial begin
        reset_n = 1'b0; enable = 1'b0; slot_mask = '0; clr_flags = 1'b0;
        resp_mask = 4'hF; resp_delay = 3;
        enable2 = 1'b0; mask2 = 4'hF; clr2 = 1'b0; done2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        reset_n = 1'b1;
        cyc = 0;

        // 1: free-running timebase with enable low
        tick_err = 0; fs_cnt = 0; fs_at = -1; req_err = 0;
        for (int i = 0; i < 12000; i++) begin
            step();
            if (tick !== (cyc % 10 == 9)) tick_err++;
            if (frame_start) begin
                fs_cnt++;
                if (fs_at < 0) fs_at = cyc;
            end
            if (req != '0) req_err++;
        end
        check("t1_tick_period", 32'(tick_err), 32'd0);
        check("t1_frame_at", 32'(fs_at), 32'd9999);
        check("t1_frame_strobes", 32'(fs_cnt), 32'd1);
        check("t1_frame_count", 32'(frame_count), 32'd1);
        check("t1_req_idle", 32'(req_err), 32'd0);

        // 2: mask 1011, all slots answer
        enable = 1'b1; slot_mask = 4'b1011;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
        wait_frame(12000, "t2_frame_seen");
        check("t2_frame_at", 32'(fs_cyc), 32'd19999);
        step();
        check("t2_busy_scan", 32'(busy), 32'd1);
        check("t2_req_scan", 32'(req), 32'd0);
        check("t2_frame_count", 32'(frame_count), 32'd2);
        step();
        check("t2_req_latency", 32'(req), 32'b0001);
        slot_mask = 4'b0000;
        wait_idle(200, "t2_idle");
        check("t2_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t2_flags", 32'(timeout_flags), 32'd0);
        check("t2_overrun", 32'(overrun), 32'd0);

        // 3: slot 1 never answers
        slot_mask = 4'b1011; resp_mask = 4'b1001;
        exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b1000);
        wait_frame(12000, "t3_frame_seen");
        check("t3_frame_at", 32'(fs_cyc), 32'd29999);
        wait_req(4'b0010, 50, "t3_req1_seen");
        t_on = cyc; n = 0;
        while (req == 4'b0010 && n < 700) begin
            step();
            n++;
        end
        dur = cyc - t_on;
        check_range("t3_timeout_len", dur, 490, 510);
        wait_idle(100, "t3_idle");
        check("t3_flags", 32'(timeout_flags), 32'b0010);
        check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // 4: short-frame instance, no done at all -> overrun
        enable2 = 1'b1; n = 0;
        while (!fs2 && n < 1100) begin
            step();
            n++;
        end
        check("t4_frame_a", 32'(fs2), 32'd1);
        fa = cyc;
        check("t4_frame_phase", 32'(fa % 1000), 32'd999);
        while (cyc < fa + 1000) step();
        check("t4_frame_b", 32'(fs2), 32'd1);
        check("t4_overrun_before", 32'(overrun2), 32'd0);
        step();
        check("t4_overrun_set", 32'(overrun2), 32'd1);
        check("t4_flags_two", 32'(flags2), 32'b0011);
        check("t4_still_busy", 32'(busy2), 32'd1);
        n = 0;
        while (req2 == '0 && n < 10) begin
            step();
            n++;
        end
        check("t4_no_restart", 32'(req2), 32'b0100);
        enable2 = 1'b0;
        while (cyc < fa + 1500) step();
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        check("t4_clr_set_wins", 32'(flags2), 32'b0100);
        check("t4_overrun_cleared", 32'(overrun2), 32'd0);
        n = 0;
        while (busy2 && n < 10) begin
            step();
            n++;
        end
        check("t4_idle", 32'(busy2), 32'd0);
        clr2 = 1'b1;
        step();
        clr2 = 1'b0;
        check("t4_flags_clear", 32'(flags2), 32'd0);

        // 5: enable dropped while slot 0 is requested
        resp_mask = 4'hF; resp_delay = 20; slot_mask = 4'b1011;
        exp_q.push_back(4'b0001);
        wait_frame(12000, "t5_frame_seen");
        check("t5_frame_at", 32'(fs_cyc), 32'd39999);
        step();
        step();
        check("t5_req0", 32'(req), 32'b0001);
        enable = 1'b0;
        repeat (10) step();
        check("t5_req_held", 32'(req), 32'b0001);
        check("t5_busy_held", 32'(busy), 32'd1);
        wait_idle(60, "t5_idle");
        repeat (20) step();
        check("t5_req_none", 32'(req), 32'd0);
        check("t5_queue_drained", 32'(exp_q.size()), 32'd0);

        // 6: asynchronous reset while slot 2 is requested
        enable = 1'b1; slot_mask = 4'b0100; resp_mask = 4'b0000; resp_delay = 3;
        exp_q.push_back(4'b0100);
        wait_frame(12000, "t6_frame_seen");
        step();
        check("t6_fcount_pre", 32'(frame_count), 32'd5);
        step();
        check("t6_req2", 32'(req), 32'b0100);
        repeat (5) step();
        #3 reset_n = 1'b0;
        #1;
        check("t6_async_req", 32'(req), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_fcount", 32'(frame_count), 32'd0);
        step();
        step();
        reset_n = 1'b1;
        cyc = 0;
        resp_mask = 4'hF;
        exp_q.push_back(4'b0100);
        wait_frame(10100, "t6_frame_resume");
        check("t6_frame_at", 32'(fs_cyc), 32'd9999);
        step();
        check("t6_fcount_post", 32'(frame_count), 32'd1);
        step();
        check("t6_req_resume", 32'(req), 32'b0100);
        wait_idle(50, "t6_idle");
        check("t6_queue_drained", 32'(exp_q.size()), 32'd0);
        check("t6_flags", 32'(timeout_flags), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
